fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that lets N_REQ producers share a single FIFO write port.
- Producers include the per-node feature/score streams feeding the GAT aggregation stage.
- Packets stay atomic: once a producer wins, it keeps the grant until its last beat.
- FIFO write signals are registered, and overflow is prevented using the FIFO's full and almost_full flags.

Parameters:
- N_REQ, 4, number of requesters (must be ≥2).
- DATA_WIDTH, 40, beat width; must equal the FIFO data width.
- ID_WIDTH, $clog2(N_REQ), width of grant_id.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_vld  input  N_REQ  per-requester beat valid.
- req_data  input  N_REQ*DATA_WIDTH  per-requester beat; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  N_REQ  marks the final beat of a packet.
- req_rdy  output  N_REQ  beat accepted this cycle (combinational).
- fifo_full  input  1  FIFO full flag.
- fifo_almost_full  input  1  FIFO has exactly one free slot.
- fifo_wr_vld  output  1  registered FIFO write strobe.
- fifo_din  output  DATA_WIDTH  registered FIFO write data.
- grant_id  output  ID_WIDTH  index of the most recently accepted requester (registered).
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0.
  - fifo_wr_vld=0, fifo_din=0, grant_id=0, busy=0.
  - req_rdy is all-zero while rst=1.
- Issue gate: issue_ok = !fifo_full && !(fifo_wr_vld && fifo_almost_full).
  - The gate covers the one beat already in the output register and not yet written.
  - It never uses FIFO read activity to predict free space.
- Accept: requester i's beat is accepted in a cycle iff req_vld[i] && req_rdy[i]. At most one req_rdy bit is high per cycle.
- Output stage, at the clock edge after an accept:
  - fifo_wr_vld<=1.
  - fifo_din<=accepted data.
  - grant_id<=i.
  - Cycles with no accept load fifo_wr_vld<=0 and leave fifo_din and grant_id unchanged.
  - Latency from accept to FIFO write strobe is 1 cycle.
- State machine:
  - IDLE:
    - If issue_ok and any req_vld is high, grant the first requester with req_vld=1 scanning from rr_ptr upward, modulo N_REQ. Assert req_rdy for that requester only.
    - If the accepted beat has req_last=1: stay IDLE and set rr_ptr<=(g+1) mod N_REQ.
    - If the accepted beat has req_last=0: go to LOCKED, set owner<=g and busy<=1.
  - LOCKED:
    - req_rdy[owner]=issue_ok. All other req_rdy bits are 0.
    - An accepted beat with req_last=1 returns the block to IDLE, sets rr_ptr<=(owner+1) mod N_REQ and clears busy.
    - If the owner drops req_vld mid-packet, the grant is held indefinitely (no timeout) and other requesters stall.
- Back-pressure: when issue_ok=0, every req_rdy bit is 0 and requesters must hold their data and last. State is unchanged.
- Fairness: a requester that is continuously valid waits at most N_REQ-1 packets before it is granted.
- Single-beat packet: req_last=1 on the first beat never enters LOCKED.
- Wrap-around: rr_ptr and owner are modulo N_REQ, and N_REQ need not be a power of two.
- Reset mid-packet:
  - The lock is dropped and any beat held in the output register is discarded (fifo_wr_vld goes to 0 immediately).
  - The FIFO is reset by the same system reset.
- Requester input signals during rst are ignored.

Test Plan:
- All 4 requesters issue single-beat packets continuously with the FIFO empty -> grant order 0,1,2,3,0,…; fifo_wr_vld stays high every cycle from the 2nd cycle; each grant_id matches the fifo_din source one cycle after its accept.
- Req1 sends a 3-beat packet with req2 valid throughout -> beats A,B,C from req1 are written consecutively with busy=1; req2 is granted only after C; rr_ptr ends at 2.
- FIFO depth 4, no reads, req0 streams continuously -> exactly 4 writes; req_rdy drops in the cycle where fifo_wr_vld=1 and almost_full=1; no write occurs while full.
- Req3 packet with req_vld gapped 2 cycles mid-packet, req0 valid -> req0 stays stalled; req3's remaining beats follow; req0 is granted next via wrap to 0.
- Assert rst for 1 cycle while LOCKED with fifo_wr_vld=1 -> fifo_wr_vld, busy and grant_id are 0 asynchronously; the first grant after reset goes to the lowest valid index.
- Only req2 is valid for 5 packets -> req2 is granted every time with no idle cycles despite rr_ptr advancing.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Groups the producer handshake and the FIFO write-port signals of
// fifo_wr_arbiter into a single bundle.
//   req_vld / req_data / req_last : per-producer beat offer
//   req_rdy                       : per-producer beat accepted (combinational)
//   fifo_full / fifo_almost_full  : FIFO occupancy flags
//   fifo_wr_vld / fifo_din        : registered FIFO write strobe and data
//   grant_id / busy               : last accepted producer, packet-lock flag
// Modports:
//   master : producers and FIFO side (drives requests and FIFO flags)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            req_vld;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_rdy;
  logic                        fifo_full;
  logic                        fifo_almost_full;
  logic                        fifo_wr_vld;
  logic [DATA_WIDTH-1:0]       fifo_din;
  logic [ID_WIDTH-1:0]         grant_id;
  logic                        busy;

  modport master (
    output req_vld, req_data, req_last, fifo_full, fifo_almost_full,
    input  req_rdy, fifo_wr_vld, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_vld, req_data, req_last, fifo_full, fifo_almost_full,
    output req_rdy, fifo_wr_vld, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter letting N_REQ producers share one FIFO write port.
// A producer that wins keeps the grant until the beat flagged last, so
// packets reach the FIFO unbroken. The write strobe and data are registered
// (one cycle from accept to write) and overflow is avoided using the FIFO's
// full and almost_full flags.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : fifo_wr_arbiter_if.slave (request handshake + FIFO write port)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  // One extra bit so rr_ptr + offset can be compared with N_REQ before wrap.
  localparam logic [ID_WIDTH:0]   N_EXT   = (ID_WIDTH+1)'(N_REQ);
  localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(N_REQ-1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_owner;
  logic                  r_fifo_wr_vld;
  logic [DATA_WIDTH-1:0] r_fifo_din;
  logic [ID_WIDTH-1:0]   r_grant_id;

  logic                  w_issue_ok;
  logic [ID_WIDTH-1:0]   w_cand [N_REQ];
  logic                  w_pick_vld;
  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic [ID_WIDTH-1:0]   w_sel_idx;
  logic [ID_WIDTH-1:0]   w_sel_inc;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [N_REQ-1:0]      w_req_rdy;
  logic                  w_busy;
  logic                  w_accept;

  // The beat sitting in the output register has not reached the FIFO yet,
  // so with a single free slot left it already claims that slot.
  assign w_issue_ok = !bus.fifo_full && !(r_fifo_wr_vld && bus.fifo_almost_full);

  // Candidate k is the requester k places after rr_ptr, wrapped modulo N_REQ
  // (N_REQ need not be a power of two, hence the explicit subtract).
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      localparam logic [ID_WIDTH:0] K_OFS = (ID_WIDTH+1)'(gi);
      logic [ID_WIDTH:0] w_sum;
      logic [ID_WIDTH:0] w_wrap;
      assign w_sum       = {1'b0, r_rr_ptr} + K_OFS;
      assign w_wrap      = w_sum - N_EXT;
      assign w_cand[gi]  = (w_sum >= N_EXT) ? w_wrap[ID_WIDTH-1:0] : w_sum[ID_WIDTH-1:0];
    end
  endgenerate

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (bus.req_vld[w_cand[k]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand[k];
      end
    end
  end

  assign w_sel_idx  = (r_state == ST_LOCKED) ? r_owner : w_pick_idx;
  assign w_sel_inc  = (w_sel_idx == ID_LAST) ? '0 : w_sel_idx + 1'b1;
  assign w_sel_last = bus.req_last[w_sel_idx];
  assign w_sel_data = bus.req_data[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept   = |(bus.req_vld & w_req_rdy);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !w_sel_last) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_accept &&  w_sel_last) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. req_rdy is held low during reset so requester inputs are
  // ignored even though the state already reads IDLE.
  always_comb begin
    w_req_rdy = '0;
    w_busy    = (r_state == ST_LOCKED);
    if (!rst && w_issue_ok) begin
      if (r_state == ST_LOCKED) begin
        w_req_rdy[r_owner] = 1'b1;
      end else if (w_pick_vld) begin
        w_req_rdy[w_pick_idx] = 1'b1;
      end
    end
  end

  // Pointer, owner and registered FIFO write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_fifo_wr_vld <= 1'b0;
      r_fifo_din    <= '0;
      r_grant_id    <= '0;
    end else begin
      r_fifo_wr_vld <= w_accept;
      if (w_accept) begin
        r_fifo_din <= w_sel_data;
        r_grant_id <= w_sel_idx;
        if (w_sel_last) begin
          r_rr_ptr <= w_sel_inc;
        end else if (r_state == ST_IDLE) begin
          r_owner <= w_sel_idx;
        end
      end
    end
  end

  assign bus.req_rdy     = w_req_rdy;
  assign bus.busy        = w_busy;
  assign bus.fifo_wr_vld = r_fifo_wr_vld;
  assign bus.fifo_din    = r_fifo_din;
  assign bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Random producers and a depth-4 FIFO occupancy model drive fifo_wr_arbiter.
// A cycle-level reference model, written from the arbitration rules, predicts
// req_rdy and the registered write port; each FIFO write is printed.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 40;
  localparam int IW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner = -1 means no packet in progress
  int            m_owner;
  int            m_ptr;
  bit            m_wr_vld;
  logic [DW-1:0] m_din;
  int            m_gid;

  // Accept predicted for the coming clock edge
  bit            p_acc;
  int            p_g;
  bit            p_last;
  logic [DW-1:0] p_data;

  // Producers: beat data = {source id, last flag, sequence number}
  bit            g_vld  [N];
  bit            g_last [N];
  int            g_left [N];
  int            g_seq  [N];
  logic [DW-1:0] g_data [N];

  // Stimulus knobs
  int        p_on;
  int        p_rd;
  int        max_len;
  bit [N-1:0] mask;

  // FIFO occupancy and observed write port
  int            f_cnt;
  bit            f_rd;
  bit            o_wr;
  logic [DW-1:0] o_din;
  int            pkt_src;

  task automatic present(input int i);
    if (g_left[i] == 0) begin
      if (!mask[i]) return;
      g_left[i] = $urandom_range(1, max_len);
    end
    g_seq[i]++;
    g_last[i] = (g_left[i] == 1);
    g_data[i] = {8'(i), g_last[i], 31'(g_seq[i])};
    g_vld[i]  = 1'b1;
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_wr_vld = 1'b0;
    m_din    = '0;
    m_gid    = 0;
    p_acc    = 1'b0;
    f_cnt    = 0;
    f_rd     = 1'b0;
    o_wr     = 1'b0;
    o_din    = '0;
    pkt_src  = -1;
  endtask

  // Clock edge: FIFO absorbs last cycle's write, model and producers advance,
  // then the registered outputs are compared.
  task automatic edge_update();
    @(posedge clk);
    if (o_wr) begin
      check("no_overflow", 64'(f_cnt < DEPTH), 64'd1);
      if (pkt_src >= 0) check("atomic_src", 64'(o_din[39:32]), 64'(pkt_src));
      pkt_src = o_din[31] ? -1 : int'(o_din[39:32]);
      $display("wr src=%0d last=%0d data=%010h fifo_cnt=%0d", o_din[39:32], o_din[31], o_din, f_cnt);
    end
    f_cnt = f_cnt + ((o_wr && f_cnt < DEPTH) ? 1 : 0) - (f_rd ? 1 : 0);

    m_wr_vld = p_acc;
    if (p_acc) begin
      m_din = p_data;
      m_gid = p_g;
      if (p_last) begin
        m_owner = -1;
        m_ptr   = (p_g + 1) % N;
      end else begin
        m_owner = p_g;
      end
      g_vld[p_g] = 1'b0;
      g_left[p_g]--;
    end
    for (int i = 0; i < N; i++)
      if (!g_vld[i] && $urandom_range(0, 99) < p_on) present(i);

    #1;
    check("fifo_wr_vld", 64'(bus.fifo_wr_vld), 64'(m_wr_vld));
    check("fifo_din", 64'(bus.fifo_din), 64'(m_din));
    check("grant_id", 64'(bus.grant_id), 64'(m_gid));
    check("busy", 64'(bus.busy), 64'(m_owner >= 0));
    if (bus.fifo_wr_vld) check("gid_vs_src", 64'(bus.grant_id), 64'(bus.fifo_din[39:32]));
    o_wr  = bus.fifo_wr_vld;
    o_din = bus.fifo_din;
  endtask

  // Drive this cycle's inputs, predict req_rdy and the accept.
  task automatic predict();
    bit         ok;
    int         g;
    logic [N-1:0] exp_rdy;
    f_rd = (f_cnt > 0) && ($urandom_range(0, 99) < p_rd);
    bus.fifo_full        = (f_cnt == DEPTH);
    bus.fifo_almost_full = (f_cnt == DEPTH-1);
    for (int i = 0; i < N; i++) begin
      bus.req_vld[i]           = g_vld[i];
      bus.req_last[i]          = g_last[i];
      bus.req_data[i*DW +: DW] = g_data[i];
    end
    #1;
    ok      = (f_cnt != DEPTH) && !(m_wr_vld && f_cnt == DEPTH-1);
    exp_rdy = '0;
    g       = -1;
    if (ok) begin
      if (m_owner >= 0) begin
        g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (g < 0 && g_vld[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
    p_acc = (g >= 0) && g_vld[g];
    if (p_acc) begin
      p_g    = g;
      p_last = g_last[g];
      p_data = g_data[g];
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      edge_update();
      predict();
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < N; i++) begin
      g_vld[i] = 1'b0; g_last[i] = 1'b0; g_left[i] = 0; g_seq[i] = 0; g_data[i] = '0;
    end
    model_reset();
    // Inputs active during reset must be ignored
    bus.req_vld          = '1;
    bus.req_last         = '1;
    bus.req_data         = '1;
    bus.fifo_full        = 1'b0;
    bus.fifo_almost_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_vld", 64'(bus.fifo_wr_vld), 64'd0);
    check("reset_din", 64'(bus.fifo_din), 64'd0);
    check("reset_grant_id", 64'(bus.grant_id), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_req_rdy", 64'(bus.req_rdy), 64'd0);
    #2 rst = 1'b0;

    // Single-beat packets from everyone, FIFO drained every cycle
    p_on = 100; p_rd = 100; max_len = 1; mask = '1;
    predict();
    run(60);

    // Mixed packets, random gaps and reads
    p_on = 70; p_rd = 60; max_len = 4;
    run(300);

    // No reads: FIFO fills, arbiter must stop issuing; then drain
    p_on = 100; p_rd = 0;
    run(40);
    p_rd = 100;
    run(40);

    // Only requester 2 starts new packets
    mask = 4'b0100; p_on = 100;
    run(60);

    // Reset while a packet is locked and a beat sits in the output register
    mask = '1; max_len = 4; p_rd = 50;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      edge_update();
      predict();
      if (m_owner >= 0 && m_wr_vld) found = 1'b1;
    end
    check("rst_setup_reached", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_wr_vld", 64'(bus.fifo_wr_vld), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_grant_id", 64'(bus.grant_id), 64'd0);
    check("midrst_req_rdy", 64'(bus.req_rdy), 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_req_rdy", 64'(bus.req_rdy), 64'd0);
    #2 rst = 1'b0;
    model_reset();
    predict();
    run(20);

    // Sparse traffic with busy FIFO
    p_on = 40; p_rd = 40;
    run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
